// File: rtl/svd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// svd_ctrl_pkg
// Shared types and constants for the SVD sequencer (svd_ctrl) and its
// rotation-sequence counter block (svd_rot_seq).
//   state_e    : controller FSM states
//   N_PAIR     : column pairs per Jacobi sweep
//   N_WORD     : DRAM depth in vector words
//   CNT_LAST   : terminal value of the data-path pass counter cnt_svd
//   SEL_*      : U/V path select encoding for mux_ctrl_1 / demux_ctrl_1
//   SRC_*      : input-vs-CORDIC select encoding for mux_ctrl_0 / demux_ctrl_0
// -----------------------------------------------------------------------------
package svd_ctrl_pkg;

    localparam int N_PAIR   = 8;
    localparam int N_WORD   = 16;
    localparam int CNT_LAST = 17;

    localparam int PAIR_W   = 3;
    localparam int ADDR_W   = 4;
    localparam int CNT_W    = 5;
    localparam int SWEEP_W  = 4;

    localparam logic SEL_U      = 1'b0;
    localparam logic SEL_V      = 1'b1;
    localparam logic SRC_IN     = 1'b0;
    localparam logic SRC_CORDIC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT_UV = 3'd1,
        ST_LOAD    = 3'd2,
        ST_ROT     = 3'd3,
        ST_DUMP    = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

    // During rotation each (pair, pass) owns one DRAM word: the pair index
    // selects a word pair and the pass bit picks the U-side or V-side word.
    function automatic logic [ADDR_W-1:0] rot_addr(input logic [PAIR_W-1:0] pair,
                                                   input logic              pass);
        return {pair, pass};
    endfunction

endpackage

// File: rtl/svd_rot_seq.sv
// -----------------------------------------------------------------------------
// svd_rot_seq
// Pass / pair / sweep counters for the Jacobi rotation phase.
//   clk, rst_n   : clock, asynchronous active-low reset
//   ce_i         : global stall (0 holds every counter)
//   clear_i      : zero all counters (issued when the load phase completes)
//   run_i        : controller is in the rotation state
//   cnt_svd_i    : data-path pass counter, 0..CNT_LAST
//   pass_o       : 0 = U pass (slot 0), 1 = V pass (slot 1)
//   pair_o       : current column-pair index
//   pass_end_o   : current pass is in its terminal cycle
//   last_pass_o  : current pass is the final pass of the final sweep
// -----------------------------------------------------------------------------
module svd_rot_seq
    import svd_ctrl_pkg::*;
#(
    parameter int N_SWEEP = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce_i,
    input  logic              clear_i,
    input  logic              run_i,
    input  logic [CNT_W-1:0]  cnt_svd_i,
    output logic              pass_o,
    output logic [PAIR_W-1:0] pair_o,
    output logic              pass_end_o,
    output logic              last_pass_o
);

    logic               pass_q,  pass_d;
    logic [PAIR_W-1:0]  pair_q,  pair_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic               advance;

    // cnt_svd only has meaning while rotating; outside that it is ignored.
    assign pass_end_o  = run_i && (cnt_svd_i == CNT_W'(CNT_LAST));
    assign advance     = ce_i && pass_end_o;
    assign last_pass_o = pass_q
                      && (pair_q  == PAIR_W'(N_PAIR - 1))
                      && (sweep_q == SWEEP_W'(N_SWEEP - 1));

    assign pass_o = pass_q;
    assign pair_o = pair_q;

    // pass toggles every pass; pair advances when the V pass completes;
    // sweep advances when pair wraps from its last value back to 0.
    always_comb begin
        pass_d  = pass_q;
        pair_d  = pair_q;
        sweep_d = sweep_q;
        if (clear_i) begin
            pass_d  = 1'b0;
            pair_d  = '0;
            sweep_d = '0;
        end else if (advance) begin
            pass_d = ~pass_q;
            if (pass_q) begin
                pair_d = pair_q + PAIR_W'(1);
                if (pair_q == PAIR_W'(N_PAIR - 1)) begin
                    sweep_d = sweep_q + SWEEP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q  <= 1'b0;
            pair_q  <= '0;
            sweep_q <= '0;
        end else if (ce_i) begin
            pass_q  <= pass_d;
            pair_q  <= pair_d;
            sweep_q <= sweep_d;
        end
    end

endmodule

// File: rtl/svd_ctrl.sv
// -----------------------------------------------------------------------------
// svd_ctrl
// Sequencer for the SVD data path. Initialises U and V to identity, loads the
// 16-word matrix A, runs N_SWEEP Jacobi sweeps over N_PAIR column pairs using
// the paired A and UV CORDIC engines, then streams A/U/V out.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begin a decomposition (sampled in IDLE only)
//   ce_svd                : global stall; 0 freezes all state
//   cnt_svd               : data-path pass counter 0..CNT_LAST
//   in_valid / in_ready   : load-word handshake
//   out_valid / out_ready : output-word handshake
//   ce_cnt                : enable for the data-path pass counter
//   ce_cordic_slot*       : CORDIC slot enables (slot0 = U pass, slot1 = V pass)
//   mux/demux_ctrl_0      : 0 = external input path, 1 = CORDIC path
//   mux/demux_ctrl_1      : 0 = U, 1 = V
//   sel_cordic_rot        : current pair index
//   dram_addr             : shared DRAM word address
//   we_a, we_u, we_v      : DRAM write strobes
//   busy                  : high in any state but IDLE
//   done                  : one-cycle completion pulse
//
// Handshakes: a word moves on a cycle where valid and ready are both high at
// the rising clock edge. in_ready and out_valid are qualified by ce_svd so a
// transfer can only complete on a cycle the controller actually advances; the
// producer (in_valid) and this block (out_valid in DUMP) keep presenting the
// word until it is taken.
// -----------------------------------------------------------------------------
module svd_ctrl
    import svd_ctrl_pkg::*;
#(
    parameter int N_SWEEP = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ce_svd,
    input  logic [4:0] cnt_svd,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       ce_cnt,
    output logic       ce_cordic_slot0_A,
    output logic       ce_cordic_slot1_A,
    output logic       ce_cordic_slot0_UV,
    output logic       ce_cordic_slot1_UV,
    output logic       mux_ctrl_0,
    output logic       demux_ctrl_0,
    output logic       mux_ctrl_1,
    output logic       demux_ctrl_1,
    output logic [2:0] sel_cordic_rot,
    output logic [3:0] dram_addr,
    output logic       we_a,
    output logic       we_u,
    output logic       we_v,
    output logic       busy,
    output logic       done
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;

    logic                load_last;
    logic                pass;
    logic [PAIR_W-1:0]   pair;
    logic                pass_end;
    logic                last_pass;
    logic                addr_last;

    assign addr_last = (addr_q == ADDR_W'(N_WORD - 1));

    svd_rot_seq #(
        .N_SWEEP (N_SWEEP)
    ) u_rot_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce_i        (ce_svd),
        .clear_i     (load_last),
        .run_i       (state_q == ST_ROT),
        .cnt_svd_i   (cnt_svd),
        .pass_o      (pass),
        .pair_o      (pair),
        .pass_end_o  (pass_end),
        .last_pass_o (last_pass)
    );

    // Next state and output decode. Every output is a function of the
    // registered state, so a stall (ce_svd=0) holds them; only the write
    // strobes, done and the handshake qualifiers see ce_svd directly.
    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        load_last          = 1'b0;
        in_ready           = 1'b0;
        out_valid          = 1'b0;
        ce_cnt             = 1'b0;
        ce_cordic_slot0_A  = 1'b0;
        ce_cordic_slot1_A  = 1'b0;
        ce_cordic_slot0_UV = 1'b0;
        ce_cordic_slot1_UV = 1'b0;
        mux_ctrl_0         = SRC_IN;
        demux_ctrl_0       = SRC_IN;
        mux_ctrl_1         = SEL_U;
        demux_ctrl_1       = SEL_U;
        sel_cordic_rot     = '0;
        dram_addr          = '0;
        we_a               = 1'b0;
        we_u               = 1'b0;
        we_v               = 1'b0;
        busy               = (state_q != ST_IDLE);
        done               = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT_UV;
                    addr_d  = '0;
                end
            end

            // Identity rows come from the data path; this block only
            // sequences the addresses and strobes.
            ST_INIT_UV: begin
                mux_ctrl_0 = SRC_IN;
                dram_addr  = addr_q;
                we_u       = ce_svd;
                we_v       = ce_svd;
                addr_d     = addr_q + ADDR_W'(1);
                if (addr_last) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                mux_ctrl_0 = SRC_IN;
                in_ready   = ce_svd;
                dram_addr  = addr_q;
                if (in_valid && ce_svd) begin
                    we_a   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    if (addr_last) begin
                        load_last = 1'b1;
                        state_d   = ST_ROT;
                    end
                end
            end

            // Each pass runs the full 0..CNT_LAST counter sweep; the result
            // is written back only in the terminal cycle of the pass.
            ST_ROT: begin
                ce_cnt             = 1'b1;
                mux_ctrl_0         = SRC_CORDIC;
                demux_ctrl_0       = SRC_CORDIC;
                mux_ctrl_1         = pass ? SEL_V : SEL_U;
                demux_ctrl_1       = pass ? SEL_V : SEL_U;
                ce_cordic_slot0_A  = ~pass;
                ce_cordic_slot0_UV = ~pass;
                ce_cordic_slot1_A  = pass;
                ce_cordic_slot1_UV = pass;
                sel_cordic_rot     = pair;
                dram_addr          = rot_addr(pair, pass);
                if (pass_end && ce_svd) begin
                    we_a = 1'b1;
                    we_u = ~pass;
                    we_v = pass;
                    if (last_pass) begin
                        state_d = ST_DUMP;
                        addr_d  = '0;
                    end
                end
            end

            ST_DUMP: begin
                demux_ctrl_0 = SRC_IN;
                out_valid    = ce_svd;
                dram_addr    = addr_q;
                if (out_ready && ce_svd) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (addr_last) begin
                        state_d = ST_FIN;
                    end
                end
            end

            ST_FIN: begin
                done    = ce_svd;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else if (ce_svd) begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_svd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_svd_ctrl
// Bench for svd_ctrl. A small model of the data-path pass counter drives
// cnt_svd. Every strobe / output-handshake / done event is packed together
// with all control outputs into one observation word and compared against
// an expected queue filled when a decomposition is started.
// -----------------------------------------------------------------------------
module tb_svd_ctrl;

    localparam int TB_SWEEP = 2;
    localparam int W        = 28;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ce_svd;
    logic [4:0] cnt_svd;
    logic       in_valid;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic       ce_cnt;
    logic       ce_cordic_slot0_A;
    logic       ce_cordic_slot1_A;
    logic       ce_cordic_slot0_UV;
    logic       ce_cordic_slot1_UV;
    logic       mux_ctrl_0;
    logic       demux_ctrl_0;
    logic       mux_ctrl_1;
    logic       demux_ctrl_1;
    logic [2:0] sel_cordic_rot;
    logic [3:0] dram_addr;
    logic       we_a;
    logic       we_u;
    logic       we_v;
    logic       busy;
    logic       done;

    int         n_checks;
    int         n_errors;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e_mon;
    int         rot_writes;
    bit         done_seen;

    svd_ctrl #(
        .N_SWEEP (TB_SWEEP)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .ce_svd             (ce_svd),
        .cnt_svd            (cnt_svd),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .out_ready          (out_ready),
        .out_valid          (out_valid),
        .ce_cnt             (ce_cnt),
        .ce_cordic_slot0_A  (ce_cordic_slot0_A),
        .ce_cordic_slot1_A  (ce_cordic_slot1_A),
        .ce_cordic_slot0_UV (ce_cordic_slot0_UV),
        .ce_cordic_slot1_UV (ce_cordic_slot1_UV),
        .mux_ctrl_0         (mux_ctrl_0),
        .demux_ctrl_0       (demux_ctrl_0),
        .mux_ctrl_1         (mux_ctrl_1),
        .demux_ctrl_1       (demux_ctrl_1),
        .sel_cordic_rot     (sel_cordic_rot),
        .dram_addr          (dram_addr),
        .we_a               (we_a),
        .we_u               (we_u),
        .we_v               (we_v),
        .busy               (busy),
        .done               (done)
    );

    // ---------------- clock / reset / data-path counter model ---------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_svd <= 5'd0;
        else if (ce_svd && ce_cnt) cnt_svd <= (cnt_svd == 5'd17) ? 5'd0 : cnt_svd + 5'd1;
    end

    // ---------------- checking ----------------------------------------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Observation word: busy,in_ready,out_valid,done,we_a,we_u,we_v,ce_cnt,
    // slot0_A,slot1_A,slot0_UV,slot1_UV,mux0,demux0,mux1,demux1,sel[3],addr[4],cnt[5]
    function automatic logic [W-1:0] obs_vec();
        return {busy, in_ready, out_valid, done, we_a, we_u, we_v, ce_cnt,
                ce_cordic_slot0_A, ce_cordic_slot1_A, ce_cordic_slot0_UV, ce_cordic_slot1_UV,
                mux_ctrl_0, demux_ctrl_0, mux_ctrl_1, demux_ctrl_1,
                sel_cordic_rot, dram_addr, cnt_svd};
    endfunction

    function automatic logic [W-1:0] v_init(input int a);
        logic [W-1:0] v = '0;
        v[27] = 1'b1; v[22] = 1'b1; v[21] = 1'b1; v[8:5] = a[3:0];
        return v;
    endfunction

    function automatic logic [W-1:0] v_load(input int a);
        logic [W-1:0] v = '0;
        v[27] = 1'b1; v[26] = 1'b1; v[23] = 1'b1; v[8:5] = a[3:0];
        return v;
    endfunction

    function automatic logic [W-1:0] v_rot(input int pass, input int pair, input int cnt, input bit we);
        logic [W-1:0] v = '0;
        int a;
        a = pair * 2 + pass;
        v[27] = 1'b1;
        v[23] = we;
        v[22] = we && (pass == 0);
        v[21] = we && (pass == 1);
        v[20] = 1'b1;
        v[19] = (pass == 0); v[18] = (pass == 1);
        v[17] = (pass == 0); v[16] = (pass == 1);
        v[15] = 1'b1; v[14] = 1'b1;
        v[13] = (pass == 1); v[12] = (pass == 1);
        v[11:9] = pair[2:0];
        v[8:5]  = a[3:0];
        v[4:0]  = cnt[4:0];
        return v;
    endfunction

    function automatic logic [W-1:0] v_dump(input int a);
        logic [W-1:0] v = '0;
        v[27] = 1'b1; v[25] = 1'b1; v[8:5] = a[3:0];
        return v;
    endfunction

    function automatic logic [W-1:0] v_fin();
        logic [W-1:0] v = '0;
        v[27] = 1'b1; v[24] = 1'b1;
        return v;
    endfunction

    // ---------------- scoreboard monitor ------------------------------------
    always @(negedge clk) begin
        if (rst_n && (we_a || we_u || we_v || done || (out_valid && out_ready))) begin
            if (exp_q.size() == 0) begin
                check_val("sb_extra", obs_vec(), '0);
            end else begin
                e_mon = exp_q.pop_front();
                check_val("sb_event", obs_vec(), e_mon);
            end
            if (we_a && ce_cnt) rot_writes++;
            if (done) done_seen = 1'b1;
        end
    end

    // ---------------- driver tasks ------------------------------------------
    task automatic push_run(input bit with_dump);
        for (int i = 0; i < 16; i++) exp_q.push_back(v_init(i));
        for (int i = 0; i < 16; i++) exp_q.push_back(v_load(i));
        for (int s = 0; s < TB_SWEEP; s++)
            for (int p = 0; p < 8; p++)
                for (int q = 0; q < 2; q++)
                    exp_q.push_back(v_rot(q, p, 17, 1'b1));
        if (with_dump) begin
            for (int i = 0; i < 16; i++) exp_q.push_back(v_dump(i));
            exp_q.push_back(v_fin());
        end
    endtask

    // Starts a run with in_valid held high, pulses start again during LOAD,
    // and checks that rotation begins after exactly 16 + 16 cycles.
    task automatic do_start();
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        in_valid = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            n++;
            if (n == 2)  start = 1'b0;
            if (n == 20) start = 1'b1;
            if (n == 23) start = 1'b0;
            if (ce_cnt) found = 1'b1;
        end
        check_val("rot_entry_cycle", n, 34);
        check_val("rot_first", obs_vec(), v_rot(0, 0, 0, 1'b0));
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- main sequence -----------------------------------------
    initial begin
        bit found;
        n_checks = 0; n_errors = 0; rot_writes = 0; done_seen = 1'b0;
        rst_n = 1'b0; start = 1'b0; ce_svd = 1'b1; in_valid = 1'b0; out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outs", obs_vec(), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // start while stalled is not taken
        ce_svd = 1'b0; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0; ce_svd = 1'b1;
        @(negedge clk);
        check_val("stalled_start", busy, 1'b0);

        // ---- run 1: full decomposition with a stall and throttled dump ----
        rot_writes = 0; done_seen = 1'b0;
        push_run(1'b1);
        @(posedge clk); #1;
        do_start();

        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk); #1;
            if (rot_writes == 3 && cnt_svd == 5'd17) found = 1'b1;
        end
        check_val("stall_reach", found, 1'b1);
        ce_svd = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_val("stall_hold", obs_vec(), v_rot(1, 1, 17, 1'b0));
        end
        @(posedge clk); #1;
        ce_svd = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk); #1;
            if (rot_writes == 16 * TB_SWEEP) found = 1'b1;
        end
        check_val("rot_writes", rot_writes, 16 * TB_SWEEP);

        out_ready = 1'b1;
        for (int i = 0; i < 200 && !done_seen; i++) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
        end
        out_ready = 1'b0;
        check_val("done_seen", done_seen, 1'b1);
        @(negedge clk);
        check_val("busy_after_done", busy, 1'b0);
        check_val("idle_outs", obs_vec(), '0);
        check_val("sb_drain", exp_q.size(), 0);

        // ---- run 2: asynchronous reset in sweep 0, pair 3 ----
        rot_writes = 0; done_seen = 1'b0;
        push_run(1'b0);
        @(posedge clk); #1;
        do_start();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk); #1;
            if (rot_writes == 6 && cnt_svd == 5'd5) found = 1'b1;
        end
        check_val("pair3_reach", found, 1'b1);
        check_val("pair3_sel", sel_cordic_rot, 3'd3);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_val("async_reset", obs_vec(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("no_done", done_seen, 1'b0);
        check_val("idle_after_reset", obs_vec(), '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/svd_ctrl.md
Name: svd_ctrl

Overview:
- Sequencer that drives the SVD data path.
- Loads the 16-word matrix A into DRAM_A, runs N_SWEEP Jacobi sweeps over 8 column pairs using the paired A and UV CORDIC engines, then streams A, U and V out.
- Consumes the data path's 0..17 pass counter (cnt_svd); generates every enable, mux/demux select, DRAM address and write strobe.

Parameters:
- N_SWEEP, 6, number of full sweeps (1..15)
- N_PAIR, 8, column pairs per sweep; sel_cordic_rot width 3
- N_WORD, 16, DRAM depth in vector words; address width 4
- CNT_LAST, 17, terminal value of cnt_svd

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a decomposition; sampled in IDLE only
- ce_svd  in  1  global stall; 0 freezes all state
- cnt_svd  in  5  pass counter from data path
- in_valid  in  1  load word valid
- in_ready  out  1  ready for load word
- out_ready  in  1  consumer accepts output word
- out_valid  out  1  output word valid on data_out_svd_A/U/V
- ce_cnt  out  1  enable data-path counter
- ce_cordic_slot0_A, ce_cordic_slot1_A, ce_cordic_slot0_UV, ce_cordic_slot1_UV  out  1 each  CORDIC slot enables
- mux_ctrl_0, demux_ctrl_0, mux_ctrl_1, demux_ctrl_1  out  1 each  path selects
- sel_cordic_rot  out  3  current pair index
- dram_addr  out  4  shared DRAM address
- we_a, we_u, we_v  out  1 each  DRAM write strobes
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset: state IDLE; all outputs 0; sweep, pair, pass and address counters 0.
- Reset mid-operation aborts to IDLE with no done pulse.
- ce_svd=0: state, counters and registered outputs hold; we_* and done forced 0 for that cycle.
- States: IDLE, INIT_UV, LOAD, ROT, DUMP, FIN.
- IDLE:
  - start=1 and ce_svd=1 -> INIT_UV.
  - start while busy is ignored.
- INIT_UV:
  - 16 cycles write identity rows to U and V: we_u=we_v=1, dram_addr=0..15.
  - mux_ctrl_0=0. Identity data is generated in the data path, not here.
  - -> LOAD.
- LOAD:
  - in_ready=1, mux_ctrl_0=0.
  - Each in_valid&in_ready: we_a=1 at dram_addr, then addr+1.
  - After word 15 -> ROT with pair=0, pass=0, sweep=0.
- ROT:
  - ce_cnt=1, demux_ctrl_0=1, mux_ctrl_0=1, sel_cordic_rot=pair, dram_addr={pair,pass}.
  - pass0: ce_cordic_slot0_A=ce_cordic_slot0_UV=1, mux_ctrl_1=demux_ctrl_1=0 (U).
  - pass1: ce_cordic_slot1_A=ce_cordic_slot1_UV=1, mux_ctrl_1=demux_ctrl_1=1 (V).
  - At cnt_svd==CNT_LAST with ce_svd=1: we_a=1, plus we_u (pass0) or we_v (pass1), for exactly that cycle; then pass toggles.
  - pass wrap increments pair; pair wrap 7->0 increments sweep.
  - After sweep N_SWEEP-1, pair 7, pass1 -> DUMP, ce_cnt=0, addr=0.
  - Data-path counter returns to 0 after 17, so passes are exactly 18 cycles back-to-back.
- DUMP:
  - demux_ctrl_0=0, out_valid=1, dram_addr=addr.
  - addr advances only on out_valid&out_ready.
  - After word 15 accepted -> FIN.
- FIN: done=1 for one cycle -> IDLE.
- cnt_svd value outside ROT is ignored.
- Counter arithmetic is unsigned modulo field width.
- sweep is 4 bits; N_SWEEP=0 is illegal.

Decomposition:
- Package svd_ctrl_pkg holds the state enum, N_PAIR, N_WORD, CNT_LAST and the select encodings (SEL_U=0, SEL_V=1, SRC_IN=0, SRC_CORDIC=1).
- One natural sub-module, svd_rot_seq, owns the pass/pair/sweep counters and pass_end/last_pass flags.
- The top holds the FSM and output decode.

Test Plan:
- Reset then start, in_valid held 1 -> 16 cycles we_u=we_v=1, then 16 cycles we_a=1 with dram_addr 0..15, then ROT entered.
- ROT timing, N_SWEEP=1:
  - first pass: slot0 enables 1, mux_ctrl_1=0.
  - we_a&we_u exactly once when cnt_svd=17.
  - next pass: slot1 enables, we_v.
  - 16 passes total, sel_cordic_rot 0,0,1,1,...,7,7.
- ce_svd low 5 cycles mid-pass -> all outputs frozen, no write strobes, pass resumes at same cnt_svd value.
- DUMP with out_ready toggling 1,0,1,0 -> dram_addr advances only on accepted cycles; 16 words; done pulses once; busy drops the cycle after.
- rst_n asserted mid-ROT (sweep 0, pair 3) -> immediate IDLE, all outputs 0, no done.
- start pulsed during LOAD -> ignored, load count unaffected.
